ccr_unit: RTL and testbench
===========================

Name: ccr_unit

Overview:
- Condition-code register (CCR) for the 8-bit pipelined core.
- Sits at the far end of the ALU flag interface. It latches the ALU's 4-bit flag vector {V,C,N,Z} under a per-opcode update mask.
- Feeds the carry back to the ALU for RLC/RRC and resolves conditional jumps (JZ/JN/JC) against the held flags.
- Provides a LIFO shadow stack so interrupt entry and RTI preserve flags.

Parameters:
- SHADOW_DEPTH, 2, number of CCR snapshots the shadow stack can hold (nested interrupts); minimum 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- alu_flags  in  4  ALU flag vector: [3]=V, [2]=C, [1]=N, [0]=Z
- alu_fun  in  6  opcode of the instruction currently in EX (same encoding as the ALU)
- ex_valid  in  1  EX holds a valid, non-flushed instruction this cycle
- br_valid  in  1  conditional jump is being resolved this cycle
- br_type  in  2  00=none, 01=JZ, 10=JN, 11=JC
- int_save  in  1  interrupt entry: push CCR snapshot
- rti_restore  in  1  RTI: pop snapshot into CCR
- ccr  out  4  current registered flags {V,C,N,Z}
- carry_out  out  1  ccr[2], ALU carry input for RLC/RRC
- br_taken  out  1  combinational jump decision
- shadow_full  out  1  stack holds SHADOW_DEPTH entries
- shadow_empty  out  1  stack holds 0 entries
- stk_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset=0 at posedge): ccr=0, stack pointer=0, stk_err=0, all stack entries=0. Resulting outputs: shadow_empty=1, shadow_full=0, carry_out=0. br_taken follows the combinational rule, so it is 0.
- ALU update, applied only when ex_valid=1. The mask is selected by alu_fun:
  - 2 (ADD), 3 (SUB), 16 (INC), 17 (DEC): write V, C, N, Z.
  - 5 (OR), 14 (NOT), 15 (NEG): write N, Z only.
  - 6 (RLC), 7 (RRC), 8 (SETC), 9 (CLRC): write C only.
  - All other codes, including 22 (LOOP): no write.
  - Bits outside the mask hold their value.
- br_taken = br_valid & selected flag: JZ→ccr[0], JN→ccr[1], JC→ccr[2]. br_type=00 gives 0. Uses the registered ccr, so there is zero-cycle latency and no dependence on same-cycle alu_flags.
- Taken jump clears the tested flag at the next posedge.
- Same-cycle conflict: if an ALU update masks the same bit a taken jump would clear, the ALU value wins.
- int_save (alone):
  - If not full: push the next-state CCR (after this cycle's ALU update and jump clear) and increment the pointer. ccr itself takes its normal next-state value.
  - If full: no push, stk_err<=1.
- rti_restore (alone):
  - If not empty: ccr<=top entry and decrement the pointer. This overrides any same-cycle ALU update or jump clear.
  - If empty: no pop, ccr updates normally, stk_err<=1.
- int_save and rti_restore asserted together: protocol error. No push, no pop, stk_err<=1. ccr updates normally.
- stk_err clears only on reset.
- Write priority on ccr: reset > valid restore > ALU update > jump clear.
- shadow_full and shadow_empty are decoded from the registered pointer.
- Reset mid-sequence discards all stacked snapshots.

Test Plan:
- Reset, then ADD update: hold reset=0 for 2 cycles → ccr=0000, shadow_empty=1, stk_err=0. Then ex_valid=1, alu_fun=2, alu_flags=1101 → next cycle ccr=1101, carry_out=1.
- Mask check: ccr=1101; alu_fun=5, alu_flags=0010 → ccr=1110. alu_fun=8, alu_flags=0100 → ccr=1110. alu_fun=22, alu_flags=1111 → ccr unchanged. ex_valid=0 with alu_fun=2 → unchanged.
- Jump resolve and clear: ccr=0101; br_valid=1, br_type=01 → br_taken=1 same cycle, next ccr=0100. JN on that value → br_taken=0, ccr unchanged. JC with a same-cycle ADD writing C=1 → ccr[2]=1.
- Shadow stack: ccr=0011; int_save → ccr=0011, shadow_empty=0. ADD writes 1000 → ccr=1000. rti_restore → ccr=0011, shadow_empty=1.
- Overflow/underflow (DEPTH=2): three int_save pulses → shadow_full=1 after the 2nd, stk_err=1 after the 3rd. Two rti_restore pulses restore snapshots in LIFO order. A 3rd rti_restore → ccr unchanged, shadow_empty=1.
- Simultaneous save/restore with one entry stacked: pointer unchanged, stk_err=1. Then reset → stack empty, stk_err=0.

Source files
------------

// File: rtl/ccr_unit.sv
// ccr_unit -- condition-code register for the 8-bit pipelined core.
//
// Holds the {V,C,N,Z} flags produced by the ALU, writing only the bits that
// the current opcode is allowed to touch. The held carry is fed back to the
// ALU for rotate-through-carry, conditional jumps are resolved against the
// held flags, and a small LIFO shadow stack preserves the flags across
// interrupt entry / RTI.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low
//   alu_flags    in   [3:0] ALU flags {V,C,N,Z}
//   alu_fun      in   [5:0] opcode of the instruction in EX
//   ex_valid     in   EX instruction is valid and not flushed
//   br_valid     in   a conditional jump is resolved this cycle
//   br_type      in   [1:0] 00 none, 01 JZ, 10 JN, 11 JC
//   int_save     in   interrupt entry, push a flag snapshot
//   rti_restore  in   return from interrupt, pop a flag snapshot
//   ccr          out  [3:0] registered flags {V,C,N,Z}
//   carry_out    out  held carry for RLC/RRC
//   br_taken     out  combinational jump decision
//   shadow_full  out  shadow stack holds SHADOW_DEPTH entries
//   shadow_empty out  shadow stack holds no entries
//   stk_err      out  sticky shadow-stack protocol error

module ccr_unit #(
  parameter int SHADOW_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] alu_flags,
  input  logic [5:0] alu_fun,
  input  logic       ex_valid,
  input  logic       br_valid,
  input  logic [1:0] br_type,
  input  logic       int_save,
  input  logic       rti_restore,
  output logic [3:0] ccr,
  output logic       carry_out,
  output logic       br_taken,
  output logic       shadow_full,
  output logic       shadow_empty,
  output logic       stk_err
);

  localparam int SP_W = $clog2(SHADOW_DEPTH + 1);

  logic [3:0]      ccr_q, ccr_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            err_q, err_d;
  logic [3:0]      stack_q [SHADOW_DEPTH];

  logic [3:0] upd_mask;
  logic [3:0] clr_mask;
  logic [3:0] ccr_norm;
  logic [3:0] top_entry;
  logic       full, empty;
  logic       push, pop, proto_err;

  // Decode which flag bits this opcode is allowed to write. Anything not
  // listed (LOOP included) leaves the flags alone, as does a flushed slot.
  always_comb begin
    upd_mask = 4'b0000;
    case (alu_fun)
      6'd2, 6'd3, 6'd16, 6'd17: upd_mask = 4'b1111;
      6'd5, 6'd14, 6'd15:       upd_mask = 4'b0011;
      6'd6, 6'd7, 6'd8, 6'd9:   upd_mask = 4'b0100;
      default:                  upd_mask = 4'b0000;
    endcase
    if (!ex_valid) begin
      upd_mask = 4'b0000;
    end
  end

  // Jump decision uses only the registered flags, so it never waits on the
  // ALU. A taken jump marks its tested flag to be cleared at the next edge.
  always_comb begin
    br_taken = 1'b0;
    clr_mask = 4'b0000;
    case (br_type)
      2'b01:   br_taken = br_valid & ccr_q[0];
      2'b10:   br_taken = br_valid & ccr_q[1];
      2'b11:   br_taken = br_valid & ccr_q[2];
      default: br_taken = 1'b0;
    endcase
    if (br_taken) begin
      case (br_type)
        2'b01:   clr_mask = 4'b0001;
        2'b10:   clr_mask = 4'b0010;
        2'b11:   clr_mask = 4'b0100;
        default: clr_mask = 4'b0000;
      endcase
    end
  end

  // Normal next-state flags: the jump clear is applied first so that an ALU
  // write to the same bit overrides it.
  assign ccr_norm = ((ccr_q & ~clr_mask) & ~upd_mask) | (alu_flags & upd_mask);

  assign full  = (sp_q == SP_W'(SHADOW_DEPTH));
  assign empty = (sp_q == '0);

  // Select the most recently pushed snapshot without indexing by the wider
  // pointer directly.
  always_comb begin
    top_entry = 4'b0000;
    for (int i = 0; i < SHADOW_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) begin
        top_entry = stack_q[i];
      end
    end
  end

  // Stack control: save and restore together is a protocol error and does
  // neither; overflow and underflow are also errors and are ignored.
  always_comb begin
    push      = int_save & ~rti_restore & ~full;
    pop       = rti_restore & ~int_save & ~empty;
    proto_err = (int_save & rti_restore)
              | (int_save & ~rti_restore & full)
              | (rti_restore & ~int_save & empty);
    ccr_d     = pop ? top_entry : ccr_norm;
    sp_d      = sp_q;
    if (push) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop) begin
      sp_d = sp_q - SP_W'(1);
    end
    err_d = err_q | proto_err;
  end

  // State registers. A push stores the flags this cycle would produce
  // anyway, so the snapshot includes this cycle's ALU update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ccr_q <= 4'b0000;
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < SHADOW_DEPTH; i++) begin
        stack_q[i] <= 4'b0000;
      end
    end else begin
      ccr_q <= ccr_d;
      sp_q  <= sp_d;
      err_q <= err_d;
      for (int i = 0; i < SHADOW_DEPTH; i++) begin
        if (push && (sp_q == SP_W'(i))) begin
          stack_q[i] <= ccr_norm;
        end
      end
    end
  end

  assign ccr          = ccr_q;
  assign carry_out    = ccr_q[2];
  assign shadow_full  = full;
  assign shadow_empty = empty;
  assign stk_err      = err_q;

endmodule

// File: tb/tb_ccr_unit.sv
// tb_ccr_unit -- scoreboard bench for ccr_unit (SHADOW_DEPTH = 2).
//
// Each directed vector drives one cycle of inputs shortly after the rising
// edge and pushes what the DUT must show during that cycle: the flags held
// from earlier cycles plus the combinational jump decision for these inputs.
// A monitor samples on the falling edge and pops/compares the queue.

module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] alu_flags;
  logic [5:0] alu_fun;
  logic       ex_valid;
  logic       br_valid;
  logic [1:0] br_type;
  logic       int_save;
  logic       rti_restore;
  logic [3:0] ccr;
  logic       carry_out;
  logic       br_taken;
  logic       shadow_full;
  logic       shadow_empty;
  logic       stk_err;

  typedef struct {
    string      name;
    logic [3:0] ccr;
    logic       br;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t expQ[$];
  int   numChecks = 0;
  int   numFails  = 0;

  ccr_unit #(.SHADOW_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_flags   (alu_flags),
    .alu_fun     (alu_fun),
    .ex_valid    (ex_valid),
    .br_valid    (br_valid),
    .br_type     (br_type),
    .int_save    (int_save),
    .rti_restore (rti_restore),
    .ccr         (ccr),
    .carry_out   (carry_out),
    .br_taken    (br_taken),
    .shadow_full (shadow_full),
    .shadow_empty(shadow_empty),
    .stk_err     (stk_err)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Single comparison, counted and reported on mismatch.
  task automatic checkOutput(input string name, input string field,
                             input logic [3:0] act, input logic [3:0] req);
    numChecks++;
    if (act !== req) begin
      numFails++;
      $display("[TB] FAIL %s.%s: got %b, expected %b", name, field, act, req);
    end
  endtask

  // Monitor: away from the active edge, compare every pending expectation.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput(e.name, "ccr",   ccr,                  e.ccr);
      checkOutput(e.name, "carry", {3'b000, carry_out},  {3'b000, e.ccr[2]});
      checkOutput(e.name, "br",    {3'b000, br_taken},   {3'b000, e.br});
      checkOutput(e.name, "full",  {3'b000, shadow_full},  {3'b000, e.full});
      checkOutput(e.name, "empty", {3'b000, shadow_empty}, {3'b000, e.empty});
      checkOutput(e.name, "err",   {3'b000, stk_err},    {3'b000, e.err});
    end
  end

  // Drive one cycle of inputs and, if chk is set, queue the expectation.
  task automatic applyStimulus(
    input string name, input logic rst_n, input logic exv,
    input logic [5:0] fun, input logic [3:0] flags,
    input logic brv, input logic [1:0] brt, input logic sv, input logic rs,
    input logic chk, input logic [3:0] eCcr, input logic eBr,
    input logic eFull, input logic eEmpty, input logic eErr);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst_n;
    ex_valid    = exv;
    alu_fun     = fun;
    alu_flags   = flags;
    br_valid    = brv;
    br_type     = brt;
    int_save    = sv;
    rti_restore = rs;
    if (chk) begin
      e.name  = name;
      e.ccr   = eCcr;
      e.br    = eBr;
      e.full  = eFull;
      e.empty = eEmpty;
      e.err   = eErr;
      expQ.push_back(e);
    end
  endtask

  initial begin
    reset = 1'b0; ex_valid = 1'b0; alu_fun = 6'd0; alu_flags = 4'b0000;
    br_valid = 1'b0; br_type = 2'b00; int_save = 1'b0; rti_restore = 1'b0;

    //             name        rst exv fun    flags    brv brt   sv rs chk ccr      br full empty err
    applyStimulus("rst0",      0, 0, 6'd0,  4'b0000, 0, 2'b00, 0, 0, 0, 4'b0000, 0, 0, 1, 0);
    applyStimulus("rst1",      0, 0, 6'd0,  4'b0000, 0, 2'b00, 0, 0, 1, 4'b0000, 0, 0, 1, 0);
    applyStimulus("add",       1, 1, 6'd2,  4'b1101, 0, 2'b00, 0, 0, 1, 4'b0000, 0, 0, 1, 0);
    applyStimulus("or",        1, 1, 6'd5,  4'b0010, 0, 2'b00, 0, 0, 1, 4'b1101, 0, 0, 1, 0);
    applyStimulus("setc",      1, 1, 6'd8,  4'b0100, 0, 2'b00, 0, 0, 1, 4'b1110, 0, 0, 1, 0);
    applyStimulus("loop",      1, 1, 6'd22, 4'b1111, 0, 2'b00, 0, 0, 1, 4'b1110, 0, 0, 1, 0);
    applyStimulus("flushed",   1, 0, 6'd2,  4'b0000, 0, 2'b00, 0, 0, 1, 4'b1110, 0, 0, 1, 0);
    applyStimulus("neg",       1, 1, 6'd15, 4'b0001, 0, 2'b00, 0, 0, 1, 4'b1110, 0, 0, 1, 0);
    applyStimulus("rrc",       1, 1, 6'd7,  4'b0000, 0, 2'b00, 0, 0, 1, 4'b1101, 0, 0, 1, 0);
    applyStimulus("nowrite4",  1, 1, 6'd4,  4'b1111, 0, 2'b00, 0, 0, 1, 4'b1001, 0, 0, 1, 0);
    applyStimulus("dec",       1, 1, 6'd17, 4'b0110, 0, 2'b00, 0, 0, 1, 4'b1001, 0, 0, 1, 0);
    applyStimulus("add0101",   1, 1, 6'd2,  4'b0101, 0, 2'b00, 0, 0, 1, 4'b0110, 0, 0, 1, 0);
    applyStimulus("jz",        1, 0, 6'd0,  4'b0000, 1, 2'b01, 0, 0, 1, 4'b0101, 1, 0, 1, 0);
    applyStimulus("jn",        1, 0, 6'd0,  4'b0000, 1, 2'b10, 0, 0, 1, 4'b0100, 0, 0, 1, 0);
    applyStimulus("jc_add",    1, 1, 6'd2,  4'b0100, 1, 2'b11, 0, 0, 1, 4'b0100, 1, 0, 1, 0);
    applyStimulus("jc",        1, 0, 6'd0,  4'b0000, 1, 2'b11, 0, 0, 1, 4'b0100, 1, 0, 1, 0);
    applyStimulus("brv0",      1, 1, 6'd2,  4'b0011, 0, 2'b01, 0, 0, 1, 4'b0000, 0, 0, 1, 0);
    applyStimulus("save",      1, 0, 6'd0,  4'b0000, 0, 2'b00, 1, 0, 1, 4'b0011, 0, 0, 1, 0);
    applyStimulus("add1000",   1, 1, 6'd2,  4'b1000, 0, 2'b00, 0, 0, 1, 4'b0011, 0, 0, 0, 0);
    applyStimulus("restore",   1, 0, 6'd0,  4'b0000, 0, 2'b00, 0, 1, 1, 4'b1000, 0, 0, 0, 0);
    applyStimulus("restored",  1, 0, 6'd0,  4'b0000, 0, 2'b00, 0, 0, 1, 4'b0011, 0, 0, 1, 0);
    applyStimulus("save_a",    1, 1, 6'd2,  4'b0110, 0, 2'b00, 1, 0, 1, 4'b0011, 0, 0, 1, 0);
    applyStimulus("save_b",    1, 1, 6'd2,  4'b1001, 0, 2'b00, 1, 0, 1, 4'b0110, 0, 0, 0, 0);
    applyStimulus("save_ovf",  1, 1, 6'd2,  4'b0001, 0, 2'b00, 1, 0, 1, 4'b1001, 0, 1, 0, 0);
    applyStimulus("rti_ovr",   1, 1, 6'd2,  4'b1111, 0, 2'b00, 0, 1, 1, 4'b0001, 0, 1, 0, 1);
    applyStimulus("rti_2",     1, 0, 6'd0,  4'b0000, 0, 2'b00, 0, 1, 1, 4'b1001, 0, 0, 0, 1);
    applyStimulus("rti_unf",   1, 1, 6'd2,  4'b0010, 0, 2'b00, 0, 1, 1, 4'b0110, 0, 0, 1, 1);
    applyStimulus("after_unf", 1, 0, 6'd0,  4'b0000, 0, 2'b00, 0, 0, 1, 4'b0010, 0, 0, 1, 1);
    applyStimulus("rst_mid",   0, 0, 6'd0,  4'b0000, 0, 2'b00, 0, 0, 1, 4'b0010, 0, 0, 1, 1);
    applyStimulus("save_1",    1, 0, 6'd0,  4'b0000, 0, 2'b00, 1, 0, 1, 4'b0000, 0, 0, 1, 0);
    applyStimulus("both",      1, 1, 6'd2,  4'b0101, 0, 2'b00, 1, 1, 1, 4'b0000, 0, 0, 0, 0);
    applyStimulus("after_both",1, 0, 6'd0,  4'b0000, 0, 2'b00, 0, 0, 1, 4'b0101, 0, 0, 0, 1);
    applyStimulus("pop_zero",  1, 0, 6'd0,  4'b0000, 0, 2'b00, 0, 1, 1, 4'b0101, 0, 0, 0, 1);
    applyStimulus("save_1100", 1, 1, 6'd2,  4'b1100, 0, 2'b00, 1, 0, 1, 4'b0000, 0, 0, 1, 1);
    applyStimulus("rst_stk",   0, 0, 6'd0,  4'b0000, 0, 2'b00, 0, 0, 1, 4'b1100, 0, 0, 0, 1);
    applyStimulus("rti_empty", 1, 0, 6'd0,  4'b0000, 0, 2'b00, 0, 1, 1, 4'b0000, 0, 0, 1, 0);
    applyStimulus("final",     1, 0, 6'd0,  4'b0000, 0, 2'b00, 0, 0, 1, 4'b0000, 0, 0, 1, 1);

    // Give the monitor a bounded number of cycles to drain the queue.
    for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    @(posedge clk);
    numChecks++;
    if (expQ.size() != 0) begin
      numFails++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
